// File: rtl/sirv_sram_icb_arb2_pkg.sv
// rtl/sirv_sram_icb_arb2_pkg.sv - shared widths and master-id type for the two-master ICB arbiter
package sirv_sram_icb_arb2_pkg;

  localparam int MID_W = 1;

  typedef enum logic [MID_W-1:0] {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_id_e;

  // read bit + addr + wdata + wmask + usr, packed for the grant mux
  function automatic int cmd_pack_w(input int aw, input int dw, input int mw, input int usr_w);
    return aw + dw + mw + usr_w + 1;
  endfunction

  function automatic int osd_cnt_w(input int osd);
    return $clog2(osd + 1);
  endfunction

  function automatic int osd_ptr_w(input int osd);
    return (osd > 1) ? $clog2(osd) : 1;
  endfunction

endpackage

// File: rtl/sirv_sram_arb_osd_fifo.sv
// rtl/sirv_sram_arb_osd_fifo.sv - outstanding-command FIFO of 1-bit master ids, depth OSD
module sirv_sram_arb_osd_fifo
  import sirv_sram_icb_arb2_pkg::*;
#(
  parameter int OSD = 2,
  localparam int CNT_W = osd_cnt_w(OSD),
  localparam int PTR_W = osd_ptr_w(OSD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             din,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [OSD-1:0]   mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // pointers wrap at OSD, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OSD - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(OSD));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sirv_sram_icb_arb2.sv
// rtl/sirv_sram_icb_arb2.sv - round-robin two-master ICB arbiter with grant lock and in-order response routing
module sirv_sram_icb_arb2
  import sirv_sram_icb_arb2_pkg::*;
#(
  parameter int DW    = 32,
  parameter int MW    = 4,
  parameter int AW    = 32,
  parameter int USR_W = 3,
  parameter int OSD   = 2
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             m0_icb_cmd_valid,
  output logic             m0_icb_cmd_ready,
  input  logic             m0_icb_cmd_read,
  input  logic [AW-1:0]    m0_icb_cmd_addr,
  input  logic [DW-1:0]    m0_icb_cmd_wdata,
  input  logic [MW-1:0]    m0_icb_cmd_wmask,
  input  logic [USR_W-1:0] m0_icb_cmd_usr,
  output logic             m0_icb_rsp_valid,
  input  logic             m0_icb_rsp_ready,
  output logic [DW-1:0]    m0_icb_rsp_rdata,
  output logic [USR_W-1:0] m0_icb_rsp_usr,

  input  logic             m1_icb_cmd_valid,
  output logic             m1_icb_cmd_ready,
  input  logic             m1_icb_cmd_read,
  input  logic [AW-1:0]    m1_icb_cmd_addr,
  input  logic [DW-1:0]    m1_icb_cmd_wdata,
  input  logic [MW-1:0]    m1_icb_cmd_wmask,
  input  logic [USR_W-1:0] m1_icb_cmd_usr,
  output logic             m1_icb_rsp_valid,
  input  logic             m1_icb_rsp_ready,
  output logic [DW-1:0]    m1_icb_rsp_rdata,
  output logic [USR_W-1:0] m1_icb_rsp_usr,

  output logic             o_icb_cmd_valid,
  input  logic             o_icb_cmd_ready,
  output logic             o_icb_cmd_read,
  output logic [AW-1:0]    o_icb_cmd_addr,
  output logic [DW-1:0]    o_icb_cmd_wdata,
  output logic [MW-1:0]    o_icb_cmd_wmask,
  output logic [USR_W-1:0] o_icb_cmd_usr,
  input  logic             o_icb_rsp_valid,
  output logic             o_icb_rsp_ready,
  input  logic [DW-1:0]    o_icb_rsp_rdata,
  input  logic [USR_W-1:0] o_icb_rsp_usr,

  output logic             arb_active
);

  localparam int CMD_W = cmd_pack_w(AW, DW, MW, USR_W);
  localparam int CNT_W = osd_cnt_w(OSD);

  mst_id_e          gnt;
  mst_id_e          rr_last;
  mst_id_e          lock_id;
  logic             lock;
  logic             cmd_hs;
  logic             rsp_hs;
  logic             gnt_valid;
  logic [CMD_W-1:0] m0_pack;
  logic [CMD_W-1:0] m1_pack;
  logic [CMD_W-1:0] o_pack;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // a stalled command keeps its grant until it handshakes
  always_comb begin
    gnt = MST_M0;
    if (lock) begin
      gnt = lock_id;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      gnt = (rr_last == MST_M0) ? MST_M1 : MST_M0;
    end else if (m1_icb_cmd_valid) begin
      gnt = MST_M1;
    end
  end

  assign m0_pack   = {m0_icb_cmd_read, m0_icb_cmd_addr, m0_icb_cmd_wdata, m0_icb_cmd_wmask, m0_icb_cmd_usr};
  assign m1_pack   = {m1_icb_cmd_read, m1_icb_cmd_addr, m1_icb_cmd_wdata, m1_icb_cmd_wmask, m1_icb_cmd_usr};
  assign o_pack    = (gnt == MST_M1) ? m1_pack : m0_pack;
  assign gnt_valid = (gnt == MST_M1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;

  assign {o_icb_cmd_read, o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_usr} = o_pack;

  assign o_icb_cmd_valid  = gnt_valid & ~fifo_full;
  assign m0_icb_cmd_ready = (gnt == MST_M0) & o_icb_cmd_ready & ~fifo_full;
  assign m1_icb_cmd_ready = (gnt == MST_M1) & o_icb_cmd_ready & ~fifo_full;
  assign cmd_hs           = o_icb_cmd_valid & o_icb_cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock    <= 1'b0;
      lock_id <= MST_M0;
      rr_last <= MST_M1;
    end else if (cmd_hs) begin
      lock    <= 1'b0;
      rr_last <= gnt;
    end else if (o_icb_cmd_valid) begin
      lock    <= 1'b1;
      lock_id <= gnt;
    end
  end

  sirv_sram_arb_osd_fifo #(
    .OSD (OSD)
  ) u_osd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_hs),
    .pop   (rsp_hs),
    .din   (gnt),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // an empty FIFO means no owner: the response is neither accepted nor routed
  assign m0_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty & ~fifo_head;
  assign m1_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty & fifo_head;
  assign o_icb_rsp_ready  = ~fifo_empty & (fifo_head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign rsp_hs           = o_icb_rsp_valid & o_icb_rsp_ready;

  assign m0_icb_rsp_rdata = o_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = o_icb_rsp_rdata;
  assign m0_icb_rsp_usr   = o_icb_rsp_usr;
  assign m1_icb_rsp_usr   = o_icb_rsp_usr;

  assign arb_active = m0_icb_cmd_valid | m1_icb_cmd_valid | o_icb_rsp_valid | (fifo_count != '0);

endmodule

// File: tb/tb_sirv_sram_icb_arb2.sv
// tb/tb_sirv_sram_icb_arb2.sv - table-driven bench for the two-master ICB arbiter
module tb_sirv_sram_icb_arb2;

  localparam logic [71:0] M0_PAY = {1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF, 3'd1};
  localparam logic [71:0] M1_PAY = {1'b0, 32'h0000_0200, 32'h2222_2222, 4'h3, 3'd6};

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic [2:0]  m0_icb_cmd_usr;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready;
  logic [31:0] m0_icb_rsp_rdata;
  logic [2:0]  m0_icb_rsp_usr;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic [2:0]  m1_icb_cmd_usr;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready;
  logic [31:0] m1_icb_rsp_rdata;
  logic [2:0]  m1_icb_rsp_usr;
  logic        o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
  logic [31:0] o_icb_cmd_addr, o_icb_cmd_wdata;
  logic [3:0]  o_icb_cmd_wmask;
  logic [2:0]  o_icb_cmd_usr;
  logic        o_icb_rsp_valid, o_icb_rsp_ready;
  logic [31:0] o_icb_rsp_rdata;
  logic [2:0]  o_icb_rsp_usr;
  logic        arb_active;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  // inputs {m0v,m1v,o_cmd_ready,o_rsp_valid,m0_rsp_ready,m1_rsp_ready}
  // expected {o_cmd_valid,grant,m0_cmd_ready,m1_cmd_ready,m0_rsp_valid,m1_rsp_valid,o_rsp_ready,arb_active}
  typedef struct packed {
    logic m0v, m1v, ocr, orv, r0, r1;
    logic ev, eg, e0r, e1r, e0v, e1v, eorr, eact;
  } vec_t;

  vec_t tbl [20];

  always #5 clk = ~clk;

  sirv_sram_icb_arb2 dut (
    .clk              (clk),
    .rst              (rst),
    .m0_icb_cmd_valid (m0_icb_cmd_valid),
    .m0_icb_cmd_ready (m0_icb_cmd_ready),
    .m0_icb_cmd_read  (m0_icb_cmd_read),
    .m0_icb_cmd_addr  (m0_icb_cmd_addr),
    .m0_icb_cmd_wdata (m0_icb_cmd_wdata),
    .m0_icb_cmd_wmask (m0_icb_cmd_wmask),
    .m0_icb_cmd_usr   (m0_icb_cmd_usr),
    .m0_icb_rsp_valid (m0_icb_rsp_valid),
    .m0_icb_rsp_ready (m0_icb_rsp_ready),
    .m0_icb_rsp_rdata (m0_icb_rsp_rdata),
    .m0_icb_rsp_usr   (m0_icb_rsp_usr),
    .m1_icb_cmd_valid (m1_icb_cmd_valid),
    .m1_icb_cmd_ready (m1_icb_cmd_ready),
    .m1_icb_cmd_read  (m1_icb_cmd_read),
    .m1_icb_cmd_addr  (m1_icb_cmd_addr),
    .m1_icb_cmd_wdata (m1_icb_cmd_wdata),
    .m1_icb_cmd_wmask (m1_icb_cmd_wmask),
    .m1_icb_cmd_usr   (m1_icb_cmd_usr),
    .m1_icb_rsp_valid (m1_icb_rsp_valid),
    .m1_icb_rsp_ready (m1_icb_rsp_ready),
    .m1_icb_rsp_rdata (m1_icb_rsp_rdata),
    .m1_icb_rsp_usr   (m1_icb_rsp_usr),
    .o_icb_cmd_valid  (o_icb_cmd_valid),
    .o_icb_cmd_ready  (o_icb_cmd_ready),
    .o_icb_cmd_read   (o_icb_cmd_read),
    .o_icb_cmd_addr   (o_icb_cmd_addr),
    .o_icb_cmd_wdata  (o_icb_cmd_wdata),
    .o_icb_cmd_wmask  (o_icb_cmd_wmask),
    .o_icb_cmd_usr    (o_icb_cmd_usr),
    .o_icb_rsp_valid  (o_icb_rsp_valid),
    .o_icb_rsp_ready  (o_icb_rsp_ready),
    .o_icb_rsp_rdata  (o_icb_rsp_rdata),
    .o_icb_rsp_usr    (o_icb_rsp_usr),
    .arb_active       (arb_active)
  );

  function automatic vec_t mk(input logic [5:0] i, input logic [7:0] e);
    return {i, e};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // a response arriving with nothing outstanding must be refused and routed nowhere
  always @(negedge clk) begin
    if (!rst && model_cnt == 0 && o_icb_rsp_valid) begin
      checks++;
      assert (!o_icb_rsp_ready && !m0_icb_rsp_valid && !m1_icb_rsp_valid)
      else begin
        errors++;
        $display("FAIL empty_rsp: got ready=%0b v0=%0b v1=%0b expected 0 0 0",
                 o_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid);
      end
    end
  end

  task automatic apply(input vec_t v, input string tag);
    logic [31:0] rd;
    logic [2:0]  us;
    rd = $urandom;
    us = 3'($urandom_range(0, 7));
    m0_icb_cmd_valid = v.m0v;
    m1_icb_cmd_valid = v.m1v;
    o_icb_cmd_ready  = v.ocr;
    o_icb_rsp_valid  = v.orv;
    m0_icb_rsp_ready = v.r0;
    m1_icb_rsp_ready = v.r1;
    o_icb_rsp_rdata  = rd;
    o_icb_rsp_usr    = us;
    @(negedge clk);
    chk({tag, ".cmd_valid"}, 128'(o_icb_cmd_valid), 128'(v.ev));
    if (v.ev)
      chk({tag, ".cmd_payload"},
          128'({o_icb_cmd_read, o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_usr}),
          128'(v.eg ? M1_PAY : M0_PAY));
    chk({tag, ".m0_cmd_ready"}, 128'(m0_icb_cmd_ready), 128'(v.e0r));
    chk({tag, ".m1_cmd_ready"}, 128'(m1_icb_cmd_ready), 128'(v.e1r));
    chk({tag, ".m0_rsp_valid"}, 128'(m0_icb_rsp_valid), 128'(v.e0v));
    chk({tag, ".m1_rsp_valid"}, 128'(m1_icb_rsp_valid), 128'(v.e1v));
    chk({tag, ".o_rsp_ready"}, 128'(o_icb_rsp_ready), 128'(v.eorr));
    chk({tag, ".arb_active"}, 128'(arb_active), 128'(v.eact));
    chk({tag, ".rsp_bcast"},
        128'({m0_icb_rsp_rdata, m0_icb_rsp_usr, m1_icb_rsp_rdata, m1_icb_rsp_usr}),
        128'({rd, us, rd, us}));
    @(posedge clk);
    if (v.ev && v.ocr) model_cnt++;
    if (v.orv && v.eorr) model_cnt--;
    #1;
  endtask

  task automatic do_reset();
    m0_icb_cmd_valid = 1'b0;
    m1_icb_cmd_valid = 1'b0;
    o_icb_cmd_ready  = 1'b0;
    o_icb_rsp_valid  = 1'b0;
    m0_icb_rsp_ready = 1'b0;
    m1_icb_rsp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_cnt = 0;
    rst = 1'b0;
  endtask

  initial begin
    {m0_icb_cmd_read, m0_icb_cmd_addr, m0_icb_cmd_wdata, m0_icb_cmd_wmask, m0_icb_cmd_usr} = M0_PAY;
    {m1_icb_cmd_read, m1_icb_cmd_addr, m1_icb_cmd_wdata, m1_icb_cmd_wmask, m1_icb_cmd_usr} = M1_PAY;
    o_icb_rsp_rdata = '0;
    o_icb_rsp_usr   = '0;
    do_reset();
    do_reset();

    tbl[0]  = mk(6'b000000, 8'b00000000);
    tbl[1]  = mk(6'b101000, 8'b10100001);
    tbl[2]  = mk(6'b001110, 8'b00101011);
    tbl[3]  = mk(6'b000000, 8'b00000000);
    tbl[4]  = mk(6'b111000, 8'b11010001);
    tbl[5]  = mk(6'b111000, 8'b10100001);
    tbl[6]  = mk(6'b111110, 8'b00000101);
    tbl[7]  = mk(6'b111110, 8'b00000101);
    tbl[8]  = mk(6'b111101, 8'b00000111);
    tbl[9]  = mk(6'b111110, 8'b11011011);
    tbl[10] = mk(6'b101101, 8'b10100111);
    tbl[11] = mk(6'b000110, 8'b00001011);
    tbl[12] = mk(6'b000000, 8'b00000000);
    tbl[13] = mk(6'b000111, 8'b00000001);
    tbl[14] = mk(6'b011000, 8'b11010001);
    tbl[15] = mk(6'b100000, 8'b10000001);
    tbl[16] = mk(6'b101000, 8'b10100001);
    tbl[17] = mk(6'b000101, 8'b00000111);
    tbl[18] = mk(6'b000110, 8'b00001011);
    tbl[19] = mk(6'b000000, 8'b00000000);

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // tie round-robin from reset: grants 0,1,0,1 with responses following in order
    do_reset();
    apply(mk(6'b111000, 8'b10100001), "tie1");
    apply(mk(6'b111110, 8'b11011011), "tie2");
    apply(mk(6'b111101, 8'b10100111), "tie3");
    apply(mk(6'b111110, 8'b11011011), "tie4");
    apply(mk(6'b000101, 8'b00000111), "tie5");
    apply(mk(6'b000000, 8'b00000000), "tie6");

    // M1 stalled while M0 joins: round-robin alone would switch to M0
    apply(mk(6'b010000, 8'b11000001), "lock1");
    apply(mk(6'b110000, 8'b11000001), "lock2");
    apply(mk(6'b110000, 8'b11000001), "lock3");
    apply(mk(6'b111000, 8'b11010001), "lock4");
    apply(mk(6'b101000, 8'b10100001), "lock5");

    // full at two outstanding; a pop frees issue only on the following cycle
    apply(mk(6'b101000, 8'b00000001), "full1");
    apply(mk(6'b101101, 8'b00000111), "full2");
    apply(mk(6'b101000, 8'b10100001), "full3");

    // reset with two outstanding discards them and restores M0 priority
    do_reset();
    apply(mk(6'b000000, 8'b00000000), "rst1");
    apply(mk(6'b000111, 8'b00000001), "rst2");
    apply(mk(6'b111000, 8'b10100001), "rst3");
    apply(mk(6'b000110, 8'b00001011), "rst4");
    apply(mk(6'b000000, 8'b00000000), "rst5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
